// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared opcode/funct constants and decode control types
package decode_stage_pkg;

    localparam logic RstEnable = 1'b1;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FUNCT_NOP  = 6'b000000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;

    // Where the second operand comes from
    typedef enum logic [1:0] {
        OP2_REG  = 2'd0,
        OP2_ZEXT = 2'd1,
        OP2_SEXT = 2'd2,
        OP2_LUI  = 2'd3
    } op2_sel_e;

    // Which instruction field names the writeback register
    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_RD   = 2'd1,
        DST_RT   = 2'd2
    } dst_sel_e;

    typedef struct packed {
        logic     use_rs;
        logic     use_rt;
        op2_sel_e op2_sel;
        dst_sel_e dst_sel;
        logic     is_special;
        logic [5:0] funct;
    } dec_ctrl_t;

endpackage

// File: rtl/decode_stage_operand_fwd_mux.sv
// rtl/decode_stage_operand_fwd_mux.sv - per-port operand select with EX/MEM bypass and load-use detect
module operand_fwd_mux
    import decode_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic [RADDR_W-1:0] addr_i,
    input  logic               used_i,
    input  logic [DATA_W-1:0]  rf_data_i,
    input  logic               ex_wr_en_i,
    input  logic               ex_is_load_i,
    input  logic [RADDR_W-1:0] ex_wr_addr_i,
    input  logic [DATA_W-1:0]  ex_data_i,
    input  logic               mem_wr_en_i,
    input  logic [RADDR_W-1:0] mem_wr_addr_i,
    input  logic [DATA_W-1:0]  mem_data_i,
    output logic [DATA_W-1:0]  operand_o,
    output logic               hazard_o
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = ex_wr_en_i  && (ex_wr_addr_i  == addr_i);
    assign mem_match = mem_wr_en_i && (mem_wr_addr_i == addr_i);

    // $0 is hardwired zero; EX beats MEM; a load in EX cannot forward and raises a hazard
    always_comb begin
        operand_o = '0;
        hazard_o  = 1'b0;
        if (used_i && (addr_i != '0)) begin
            hazard_o = ex_match && ex_is_load_i;
            if (FWD_EN && ex_match && !ex_is_load_i) begin
                operand_o = ex_data_i;
            end else if (FWD_EN && mem_match) begin
                operand_o = mem_data_i;
            end else begin
                operand_o = rf_data_i;
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: decode, forwarding, load-use stall, ID/EX register
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_pc,
    input  logic [31:0]        in_inst,
    output logic               rf_en_1,
    output logic               rf_en_2,
    output logic [RADDR_W-1:0] rf_addr_1,
    output logic [RADDR_W-1:0] rf_addr_2,
    input  logic [DATA_W-1:0]  rf_data_1,
    input  logic [DATA_W-1:0]  rf_data_2,
    input  logic               ex_wr_en,
    input  logic               ex_is_load,
    input  logic [RADDR_W-1:0] ex_wr_addr,
    input  logic [DATA_W-1:0]  ex_wr_data,
    input  logic               mem_wr_en,
    input  logic [RADDR_W-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0]  mem_wr_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [5:0]         out_funct,
    output logic [DATA_W-1:0]  out_op1,
    output logic [DATA_W-1:0]  out_op2,
    output logic [4:0]         out_shamt,
    output logic               out_wr_en,
    output logic [RADDR_W-1:0] out_wr_addr
);

    logic [5:0]         opcode;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic [RADDR_W-1:0] rd;
    logic [15:0]        imm;
    dec_ctrl_t          ctrl;

    logic [DATA_W-1:0]  fwd_op1;
    logic [DATA_W-1:0]  fwd_op2;
    logic               hazard_1;
    logic               hazard_2;
    logic               stall;
    logic               accept;

    logic [DATA_W-1:0]  op2_d;
    logic [DATA_W+15:0] lui_wide;
    logic [4:0]         shamt_d;
    logic               wr_en_d;
    logic [RADDR_W-1:0] wr_addr_d;

    logic               out_valid_q;
    logic [31:0]        out_pc_q;
    logic [5:0]         out_funct_q;
    logic [DATA_W-1:0]  out_op1_q;
    logic [DATA_W-1:0]  out_op2_q;
    logic [4:0]         out_shamt_q;
    logic               out_wr_en_q;
    logic [RADDR_W-1:0] out_wr_addr_q;

    assign opcode = in_inst[31:26];
    assign rs     = RADDR_W'(in_inst[25:21]);
    assign rt     = RADDR_W'(in_inst[20:16]);
    assign rd     = RADDR_W'(in_inst[15:11]);
    assign imm    = in_inst[15:0];

    // Opcode table: which ports are read, how op2 is formed, where the result goes
    always_comb begin
        ctrl = '{use_rs: 1'b0, use_rt: 1'b0, op2_sel: OP2_REG, dst_sel: DST_NONE,
                 is_special: 1'b0, funct: FUNCT_NOP};
        unique case (opcode)
            OP_SPECIAL: ctrl = '{1'b1, 1'b1, OP2_REG,  DST_RD, 1'b1, in_inst[5:0]};
            OP_ORI:     ctrl = '{1'b1, 1'b0, OP2_ZEXT, DST_RT, 1'b0, FUNCT_OR};
            OP_ANDI:    ctrl = '{1'b1, 1'b0, OP2_ZEXT, DST_RT, 1'b0, FUNCT_AND};
            OP_XORI:    ctrl = '{1'b1, 1'b0, OP2_ZEXT, DST_RT, 1'b0, FUNCT_XOR};
            OP_ADDIU:   ctrl = '{1'b1, 1'b0, OP2_SEXT, DST_RT, 1'b0, FUNCT_ADDU};
            OP_LUI:     ctrl = '{1'b0, 1'b0, OP2_LUI,  DST_RT, 1'b0, FUNCT_OR};
            default:    ctrl = '{1'b0, 1'b0, OP2_REG,  DST_NONE, 1'b0, FUNCT_NOP};
        endcase
    end

    assign rf_en_1   = ctrl.use_rs;
    assign rf_en_2   = ctrl.use_rt;
    assign rf_addr_1 = ctrl.use_rs ? rs : '0;
    assign rf_addr_2 = ctrl.use_rt ? rt : '0;

    operand_fwd_mux #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .FWD_EN  (FWD_EN)
    ) u_fwd_1 (
        .addr_i        (rf_addr_1),
        .used_i        (ctrl.use_rs),
        .rf_data_i     (rf_data_1),
        .ex_wr_en_i    (ex_wr_en),
        .ex_is_load_i  (ex_is_load),
        .ex_wr_addr_i  (ex_wr_addr),
        .ex_data_i     (ex_wr_data),
        .mem_wr_en_i   (mem_wr_en),
        .mem_wr_addr_i (mem_wr_addr),
        .mem_data_i    (mem_wr_data),
        .operand_o     (fwd_op1),
        .hazard_o      (hazard_1)
    );

    operand_fwd_mux #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .FWD_EN  (FWD_EN)
    ) u_fwd_2 (
        .addr_i        (rf_addr_2),
        .used_i        (ctrl.use_rt),
        .rf_data_i     (rf_data_2),
        .ex_wr_en_i    (ex_wr_en),
        .ex_is_load_i  (ex_is_load),
        .ex_wr_addr_i  (ex_wr_addr),
        .ex_data_i     (ex_wr_data),
        .mem_wr_en_i   (mem_wr_en),
        .mem_wr_addr_i (mem_wr_addr),
        .mem_data_i    (mem_wr_data),
        .operand_o     (fwd_op2),
        .hazard_o      (hazard_2)
    );

    assign stall = hazard_1 | hazard_2;

    // A flush frees the output register, so the offered instruction is consumed and dropped
    assign in_ready = (rst != RstEnable) &&
                      (flush || (!stall && (!out_valid_q || out_ready)));
    assign accept   = in_valid && in_ready;

    // Second operand, shift amount and writeback target from the decoded controls
    always_comb begin
        lui_wide = '0;
        lui_wide[31:16] = imm;
        op2_d = '0;
        unique case (ctrl.op2_sel)
            OP2_REG:  op2_d = fwd_op2;
            OP2_ZEXT: op2_d = {{(DATA_W-16){1'b0}}, imm};
            OP2_SEXT: op2_d = {{(DATA_W-16){imm[15]}}, imm};
            OP2_LUI:  op2_d = lui_wide[DATA_W-1:0];
            default:  op2_d = '0;
        endcase
        shamt_d   = ctrl.is_special ? in_inst[10:6] : 5'd0;
        wr_en_d   = (ctrl.dst_sel != DST_NONE);
        wr_addr_d = (ctrl.dst_sel == DST_RD) ? rd :
                    (ctrl.dst_sel == DST_RT) ? rt : '0;
    end

    // ID/EX register: reset > flush > accept > drain; fields only change on accept
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_funct_q   <= '0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_shamt_q   <= '0;
            out_wr_en_q   <= 1'b0;
            out_wr_addr_q <= '0;
        end else if (flush) begin
            out_valid_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_pc_q      <= in_pc;
            out_funct_q   <= ctrl.funct;
            out_op1_q     <= fwd_op1;
            out_op2_q     <= op2_d;
            out_shamt_q   <= shamt_d;
            out_wr_en_q   <= wr_en_d;
            out_wr_addr_q <= wr_addr_d;
        end else if (out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_funct   = out_funct_q;
    assign out_op1     = out_op1_q;
    assign out_op2     = out_op2_q;
    assign out_shamt   = out_shamt_q;
    assign out_wr_en   = out_wr_en_q;
    assign out_wr_addr = out_wr_addr_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_pc;
    logic [31:0]        in_inst;
    logic               rf_en_1, rf_en_2;
    logic [RADDR_W-1:0] rf_addr_1, rf_addr_2;
    logic [DATA_W-1:0]  rf_data_1, rf_data_2;
    logic               ex_wr_en, ex_is_load;
    logic [RADDR_W-1:0] ex_wr_addr;
    logic [DATA_W-1:0]  ex_wr_data;
    logic               mem_wr_en;
    logic [RADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0]  mem_wr_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_pc;
    logic [5:0]         out_funct;
    logic [DATA_W-1:0]  out_op1, out_op2;
    logic [4:0]         out_shamt;
    logic               out_wr_en;
    logic [RADDR_W-1:0] out_wr_addr;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .FWD_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .rf_en_1     (rf_en_1),
        .rf_en_2     (rf_en_2),
        .rf_addr_1   (rf_addr_1),
        .rf_addr_2   (rf_addr_2),
        .rf_data_1   (rf_data_1),
        .rf_data_2   (rf_data_2),
        .ex_wr_en    (ex_wr_en),
        .ex_is_load  (ex_is_load),
        .ex_wr_addr  (ex_wr_addr),
        .ex_wr_data  (ex_wr_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_funct   (out_funct),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_shamt   (out_shamt),
        .out_wr_en   (out_wr_en),
        .out_wr_addr (out_wr_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h0000_0040;
        in_inst = enc_i(6'b001101, 0, 1, 16'h00FF);
        rf_data_1 = 32'hDEAD; rf_data_2 = 32'hBEEF;
        ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = '0; ex_wr_data = '0;
        mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;

        tick(); tick();
        chk("rst_valid",   out_valid, 0);
        chk("rst_op2",     out_op2, 0);
        chk("rst_wr_en",   out_wr_en, 0);
        chk("rst_pc",      out_pc, 0);
        chk("rst_funct",   out_funct, 0);
        chk("rst_ready",   in_ready, 0);

        // ORI $1,$0,0x00FF
        rst = 1'b0; in_pc = 32'h100;
        in_inst = enc_i(6'b001101, 0, 1, 16'h00FF);
        #1;
        chk("ori_ready",   in_ready, 1);
        chk("ori_rf_en2",  rf_en_2, 0);
        tick();
        chk("ori_valid",   out_valid, 1);
        chk("ori_op1",     out_op1, 0);
        chk("ori_op2",     out_op2, 32'h0000_00FF);
        chk("ori_funct",   out_funct, 6'b100101);
        chk("ori_wr_addr", out_wr_addr, 1);
        chk("ori_wr_en",   out_wr_en, 1);
        chk("ori_pc",      out_pc, 32'h100);

        // ADDIU $2,$3,0xFFFF with rs value 5
        in_pc = 32'h104; rf_data_1 = 32'd5;
        in_inst = enc_i(6'b001001, 3, 2, 16'hFFFF);
        #1;
        chk("addiu_raddr", rf_addr_1, 3);
        tick();
        chk("addiu_op1",   out_op1, 5);
        chk("addiu_op2",   out_op2, 32'hFFFF_FFFF);
        chk("addiu_funct", out_funct, 6'b100001);
        chk("addiu_wr",    out_wr_addr, 2);

        // LUI $4,0x1234
        in_pc = 32'h108;
        in_inst = enc_i(6'b001111, 7, 4, 16'h1234);
        #1;
        chk("lui_rf_en1",  rf_en_1, 0);
        tick();
        chk("lui_op1",     out_op1, 0);
        chk("lui_op2",     out_op2, 32'h1234_0000);
        chk("lui_shamt",   out_shamt, 0);

        // OR $5,$6,$7: EX forwards $6, MEM forwards $7
        in_pc = 32'h10C; rf_data_1 = 32'h111; rf_data_2 = 32'h222;
        in_inst = enc_r(6, 7, 5, 3, 6'b100101);
        ex_wr_en = 1'b1; ex_wr_addr = 5'd6; ex_wr_data = 32'hA;
        mem_wr_en = 1'b1; mem_wr_addr = 5'd7; mem_wr_data = 32'hB;
        tick();
        chk("fwd_op1",     out_op1, 32'hA);
        chk("fwd_op2",     out_op2, 32'hB);
        chk("fwd_shamt",   out_shamt, 3);
        chk("fwd_wr",      out_wr_addr, 5);

        // EX and MEM both target $6: EX wins, $7 from RF
        mem_wr_addr = 5'd6;
        tick();
        chk("prio_op1",    out_op1, 32'hA);
        chk("prio_op2",    out_op2, 32'h222);

        // Source $0 with EX writing $0 must read zero
        in_inst = enc_r(0, 7, 5, 0, 6'b100101);
        ex_wr_addr = 5'd0; mem_wr_en = 1'b0;
        tick();
        chk("zero_op1",    out_op1, 0);
        chk("zero_op2",    out_op2, 32'h222);

        // Load in EX writing $6, decode OR $5,$6,$7
        in_pc = 32'h110;
        in_inst = enc_r(6, 7, 5, 0, 6'b100101);
        ex_is_load = 1'b1; ex_wr_addr = 5'd6; ex_wr_data = 32'h99;
        #1;
        chk("lu_ready",    in_ready, 0);
        tick();
        chk("lu_bubble",   out_valid, 0);
        // Load moves to MEM
        ex_is_load = 1'b0; ex_wr_en = 1'b0;
        mem_wr_en = 1'b1; mem_wr_addr = 5'd6; mem_wr_data = 32'hC;
        #1;
        chk("lu_ready2",   in_ready, 1);
        tick();
        chk("lu_valid",    out_valid, 1);
        chk("lu_op1",      out_op1, 32'hC);
        chk("lu_pc",       out_pc, 32'h110);

        // Backpressure for 3 cycles
        mem_wr_en = 1'b0; out_ready = 1'b0;
        in_pc = 32'h200;
        in_inst = enc_i(6'b001101, 0, 8, 16'h0055);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready",  in_ready, 0);
            tick();
            chk("bp_valid",  out_valid, 1);
            chk("bp_op1",    out_op1, 32'hC);
            chk("bp_pc",     out_pc, 32'h110);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release",  in_ready, 1);
        tick();
        chk("bp_next_op2", out_op2, 32'h55);
        chk("bp_next_wr",  out_wr_addr, 8);

        // Flush with valid output and an offered instruction
        flush = 1'b1; in_pc = 32'h300;
        in_inst = enc_i(6'b001110, 0, 9, 16'h0007);
        #1;
        chk("fl_ready",    in_ready, 1);
        tick();
        chk("fl_valid",    out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl_gone",     out_valid, 0);

        // Unknown opcode 0x3F decodes to a valid NOP
        in_valid = 1'b1; in_pc = 32'h400;
        in_inst = 32'hFC00_0000 | enc_i(6'b000000, 6, 7, 16'h1234);
        #1;
        chk("nop_rf_en1",  rf_en_1, 0);
        tick();
        chk("nop_valid",   out_valid, 1);
        chk("nop_wr_en",   out_wr_en, 0);
        chk("nop_funct",   out_funct, 0);
        chk("nop_op2",     out_op2, 0);
        chk("nop_pc",      out_pc, 32'h400);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the MIPS pipeline, between IF and EX. Decodes one instruction per cycle into EX operands, ALU function, shift amount and writeback target, and holds them in an ID/EX output register. Adds EX/MEM operand forwarding, load-use stall detection, a valid/ready handshake on both sides, and a flush input.

## Interface
- DATA_W, 32, datapath width (≥16)
- RADDR_W, 5, register address width
- FWD_EN, 1, 1 = forwarding enabled; 0 = forwarding muxes bypassed (RF data only)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard the output register and the instruction in decode
- in_valid  in  1  IF offers in_pc/in_inst
- in_ready  out  1  decode accepts this cycle
- in_pc  in  32  instruction address
- in_inst  in  32  instruction word
- rf_en_1, rf_en_2  out  1 each  RF read enables (combinational)
- rf_addr_1, rf_addr_2  out  RADDR_W each  RF read addresses (combinational)
- rf_data_1, rf_data_2  in  DATA_W each  RF read data, same cycle
- ex_wr_en, ex_is_load  in  1 each  instruction in EX writes a register / is a load
- ex_wr_addr  in  RADDR_W  EX destination
- ex_wr_data  in  DATA_W  EX result
- mem_wr_en  in  1  MEM writes a register
- mem_wr_addr  in  RADDR_W  MEM destination
- mem_wr_data  in  DATA_W  MEM result
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  EX accepts
- out_pc  out  32  registered in_pc
- out_funct  out  6  ALU function
- out_op1, out_op2  out  DATA_W each  operands
- out_shamt  out  5  shift amount
- out_wr_en  out  1  writeback enable
- out_wr_addr  out  RADDR_W  writeback register

## Operation
- Decode by opcode inst[31:26]:
  - SPECIAL 000000: read rs and rt; funct = inst[5:0]; shamt = inst[10:6]; op1 = rs value; op2 = rt value; write rd.
  - ORI 001101 / ANDI 001100 / XORI 001110: read rs; op2 = zero-extended imm; funct OR 100101 / AND 100100 / XOR 100110; write rt.
  - ADDIU 001001: read rs; op2 = sign-extended imm; funct ADDU 100001; write rt.
  - LUI 001111: no reads; op1 = 0; op2 = imm << 16; funct OR; write rt.
  - Other opcodes: valid NOP with funct 000000, operands 0, out_wr_en 0.
- shamt is 0 for non-SPECIAL instructions. Addresses/enables of unused read ports are 0.
- Extension to DATA_W: zero-extension pads with zeros, sign-extension replicates imm[15]. LUI shift is truncated to DATA_W.
- Operand source per used port, in priority order:
  - address 0 → value 0.
  - EX match (ex_wr_en, not a load) → ex_wr_data.
  - MEM match → mem_wr_data.
  - otherwise RF data.
- FWD_EN=0: always RF data, except address 0 still reads 0.
- Load-use hazard: ex_is_load & ex_wr_en & ex_wr_addr≠0 & ex_wr_addr equals a used source. Then stall = 1.
- in_ready = !stall & (!out_valid | out_ready).
- Output register update, in priority order:
  - rst → all outputs 0.
  - flush → out_valid 0.
  - in_valid & in_ready → load decoded fields, out_valid 1.
  - out_ready → out_valid 0 (a bubble is inserted on stall).
  - otherwise hold.
- While out_valid & !out_ready, every output field is held stable.

## Timing
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction per cycle with no stalls.
- RF interface is combinational in the same cycle. Forwarding inputs are sampled in the accept cycle.
- Reset value of every output register (out_*) is 0. in_ready is low during rst.
- flush together with in_valid: the instruction is dropped, in_ready is high, and out_valid is 0 in the next cycle.
- Stall persists while the hazard condition holds. It clears the cycle after the load leaves EX, when MEM forwarding supplies the data.
- Simultaneous EX and MEM match to the same register: EX wins.

## Structure
- Shared package/include: opcode constants (OP_SPECIAL, OP_ORI, OP_ANDI, OP_XORI, OP_ADDIU, OP_LUI), funct constants (FUNCT_OR, FUNCT_AND, FUNCT_XOR, FUNCT_ADDU, FUNCT_NOP), RstEnable.
- Sub-module: operand_fwd_mux, instantiated twice. Inputs: address, used flag, RF/EX/MEM data. Outputs: operand and hazard flag.
- Decode, hazard and the output register live in decode_stage.

## Test plan
- Reset: drive rst for 2 cycles with in_valid=1 → all out_* = 0, out_valid = 0. After release, ORI $1,$0,0x00FF → next cycle op1=0, op2=0x000000FF, funct=100101, wr_addr=1, wr_en=1.
- ADDIU $2,$3,0xFFFF with rf_data_1=5 → op2=0xFFFFFFFF, funct=100001. LUI $4,0x1234 → op1=0, op2=0x12340000.
- Forwarding: SPECIAL OR $5,$6,$7 with ex_wr_addr=6 (data 0xA) and mem_wr_addr=7 (data 0xB) → op1=0xA, op2=0xB. Same instruction with both EX and MEM on $6 → op1 = EX data. Source $0 with ex_wr_addr=0 → op1=0.
- Load-use: ex_is_load, ex_wr_addr=6, decode OR $5,$6,$7 → in_ready=0 and a bubble (out_valid=0) for 1 cycle. Load moves to MEM → the instruction is accepted with the MEM-forwarded op1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → outputs held, in_ready=0. out_ready=1 → the next instruction appears next cycle.
- flush with valid output and in_valid → out_valid=0 next cycle and the flushed instruction never appears. An unknown opcode 0x3F → out_valid=1, wr_en=0, funct=0.
